channel_buffer: RTL
===================

CHANNEL_BUFFER -- requirements
Module: channel_buffer

Interface
REQ-001 Parameter DEPTH, default 4: buffer entries; power of two, 2..64.
REQ-002 Parameter CW, default $clog2(DEPTH+1): width of occupancy output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in  channel_iface.in modport  valid 1 / data DW / ready 1 / latency LW  upstream channel (DW, LW from interface parameters).
REQ-006 out  channel_iface.out modport  valid 1 / data DW / ready 1 / latency LW  downstream channel, typically a switch input.
REQ-007 occupancy  output  CW  number of entries currently stored.

Function
REQ-008 The block SHALL be a FIFO of DEPTH entries of DW bits, placed on each switch input so ring hops are registered.
REQ-009 Push SHALL occur when in.valid && in.ready; pop SHALL occur when out.valid && out.ready.
REQ-010 out.valid SHALL equal (occupancy != 0); out.data SHALL be the oldest entry (first-word fall-through, driven from storage, not from in.data).
REQ-011 Write-to-read latency SHALL be exactly 1 cycle: data pushed at edge N is visible on out at N+1.
REQ-012 in.ready SHALL equal (occupancy != DEPTH) unless modified by REQ-022.
REQ-013 Simultaneous push and pop SHALL leave occupancy unchanged, advance both pointers, and preserve ordering.
REQ-014 Read/write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without gaps.
REQ-015 Push when full (not accepted) and pop when empty SHALL have no effect on state; no data is lost, duplicated, or reordered.
REQ-016 in.latency SHALL be a register updated every cycle to min(out.latency + occupancy_next, 2^LW - 1), computed at LW+1 bits and saturated.
REQ-017 occupancy_next SHALL be the post-edge occupancy, so latency reflects the queue that new traffic will join.
REQ-018 out.valid and out.data SHALL be stable while out.valid && !out.ready; the holding entry is not changed by pushes.
REQ-019 The block SHALL contain no combinational path from in.valid or in.data to any out signal.

Reset
REQ-020 On rst high at a clock edge, pointers, occupancy and in.latency SHALL clear to 0; out.valid = 0 and in.ready = 1 from the next cycle; storage contents are not reset.
REQ-021 rst asserted mid-operation SHALL discard all queued entries; a push or pop coincident with rst SHALL be ignored.

Configuration
REQ-022 Macro CHANNEL_BUFFER_FULL_BYPASS_EN defined: in.ready = (occupancy != DEPTH) || out.ready, so a full buffer accepts a push in the same cycle as a pop. This adds a combinational out.ready -> in.ready path.
REQ-023 Macro undefined: in.ready depends only on registered state, per REQ-012; a full buffer accepts input one cycle after a pop.

Verification
REQ-024 The bench SHALL cover all of the following directed scenarios (DEPTH=4, LW=8).
- Fill: out.ready=0, push A,B,C,D on 4 edges -> occupancy 4, in.ready=0, out.data=A; a 5th valid word E is not accepted.
- Drain order: from full, out.ready=1, in.valid=0 -> out.data A,B,C,D on successive cycles; out.valid=0 after 4 pops; occupancy 0.
- Wrap and streaming: continuous push and pop for 10 words -> occupancy holds at 1, output sequence equals input sequence, pointers wrap twice.
- Full bypass: full, out.ready=1, in.valid=1 -> with macro, push accepted and occupancy stays 4; without macro, in.ready=0 that cycle and is 1 the next.
- Latency: occupancy 3 after edge, out.latency=10 -> in.latency=13 next cycle; out.latency=254 with occupancy 3 -> in.latency=255 (saturated).
- Reset mid-stream: rst at occupancy 2 with push and pop asserted -> occupancy 0, out.valid=0, in.latency=0, in.ready=1; neither the push nor the pop takes effect.

Source files
------------

// File: rtl/channel_buffer_if.sv
// Channel interface: valid/data flow downstream, ready/latency flow upstream.
interface channel_iface #(
    parameter int DW = 8,
    parameter int LW = 8
);
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic [LW-1:0] latency;

    // Seen from the buffer: the upstream channel it receives words on
    modport in  (input  valid, input  data, output ready, output latency);
    // Seen from the buffer: the downstream channel it presents words on
    modport out (output valid, output data, input  ready, input  latency);
endinterface

// File: rtl/channel_buffer.sv
// channel_buffer: first-word fall-through FIFO placed in front of each switch
// input so that every ring hop is registered. Also reports upstream the
// expected queueing latency (downstream latency + own occupancy, saturated).
//
// Optional build macro CHANNEL_BUFFER_FULL_BYPASS_EN: a full buffer accepts a
// push in the same cycle as a pop (adds out.ready -> in.ready comb path).
// Default: in.ready depends on registered state only.
module channel_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    channel_iface.in      in,
    channel_iface.out     out,
    output logic [CW-1:0] occupancy
);
    localparam int DW = $bits(in.data);
    localparam int LW = $bits(in.latency);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = ((LW > CW) ? LW : CW) + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [SW-1:0] lat_sum;
    logic          push, pop;
    logic          not_full;

    assign not_full  = (cnt_q != CW'(DEPTH));
`ifdef CHANNEL_BUFFER_FULL_BYPASS_EN
    // Slot freed by a same-cycle pop may be refilled immediately
    assign in.ready  = not_full || out.ready;
`else
    assign in.ready  = not_full;
`endif
    assign out.valid  = (cnt_q != '0);
    assign out.data   = mem_q[rd_q];
    assign in.latency = lat_q;
    assign occupancy  = cnt_q;

    assign push = in.valid && in.ready;
    assign pop  = out.valid && out.ready;

    // Next pointers, occupancy and saturated latency estimate
    always_comb begin
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (!push && pop)
            cnt_d = cnt_q - CW'(1);
        // Use post-edge occupancy: this is the queue new traffic will join
        lat_sum = SW'(out.latency) + SW'(cnt_d);
        if (lat_sum > SW'({LW{1'b1}}))
            lat_d = {LW{1'b1}};
        else
            lat_d = lat_sum[LW-1:0];
    end

    // Control state; reset discards queued entries and ignores coincident push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            lat_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            lat_q <= lat_d;
        end
    end

    // Storage is not reset; a write never touches the entry being read unless
    // that entry is popped in the same cycle
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem_q[wr_q] <= in.data;
    end
endmodule
